// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the MIPS memory-port arbiter.
//   MIPS_XLEN    : datapath / bus width
//   arb_state_e  : arbiter FSM encodings (ARB_IDLE, ARB_DATA, ARB_INST)
package mem_port_arbiter_pkg;

    localparam int MIPS_XLEN = 32;
    localparam int MIPS_NOP  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_DATA = 2'd1,
        ARB_INST = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_timeout_timer.sv
// Loadable down-counter guarding an outstanding bus transaction.
//   clk, rst_n : clock, synchronous active-low clear
//   load       : reload to TIMEOUT_CYCLES-1 (held while the bus is idle)
//   en         : count down one per cycle
//   expire     : count has reached zero (last permitted cycle)
module arb_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = CW'(TIMEOUT_CYCLES - 1);
        else if (en && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expire = (cnt_q == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch and the
// MEM stage. A 1-entry tagged fetch buffer and a 1-entry data buffer hold the
// results; mem_stall freezes the pipeline while either side is unsatisfied.
//   inst_ren/inst_addr -> inst_data      : fetch side
//   mem_ren/mem_wen/mem_addr/mem_dout -> mem_din : data side
//   bus_req/we/addr/wdata, bus_ack/rdata : memory bus (ack carries rdata)
//   bus_err : sticky, set when a transaction times out
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inst_ren,
    input  logic [MIPS_XLEN-1:0] inst_addr,
    output logic [MIPS_XLEN-1:0] inst_data,
    input  logic                 mem_ren,
    input  logic                 mem_wen,
    input  logic [MIPS_XLEN-1:0] mem_addr,
    input  logic [MIPS_XLEN-1:0] mem_dout,
    output logic [MIPS_XLEN-1:0] mem_din,
    output logic                 mem_stall,
    output logic                 bus_req,
    output logic                 bus_we,
    output logic [MIPS_XLEN-1:0] bus_addr,
    output logic [MIPS_XLEN-1:0] bus_wdata,
    input  logic                 bus_ack,
    input  logic [MIPS_XLEN-1:0] bus_rdata,
    output logic                 bus_err
);
    arb_state_e           state_q, state_d;
    logic                 ibuf_v_q, ibuf_v_d, dbuf_v_q, dbuf_v_d;
    logic [MIPS_XLEN-1:0] ibuf_tag_q, ibuf_tag_d;
    logic [MIPS_XLEN-1:0] inst_data_q, inst_data_d, mem_din_q, mem_din_d;
    logic                 bus_req_q, bus_req_d, bus_we_q, bus_we_d;
    logic [MIPS_XLEN-1:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
    logic                 bus_err_q, bus_err_d;
    logic                 d_pend, i_pend, tmr_expire, done;
    logic [MIPS_XLEN-1:0] rdata;

    arb_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (state_q == ARB_IDLE),
        .en     (state_q != ARB_IDLE),
        .expire (tmr_expire)
    );

    assign d_pend    = (mem_ren | mem_wen) & ~dbuf_v_q;
    assign i_pend    = inst_ren & ~(ibuf_v_q & (ibuf_tag_q == inst_addr));
    assign mem_stall = ~rst_n | d_pend | i_pend | (state_q != ARB_IDLE);

    // A timeout completes the transaction exactly like an ack, with error data.
    assign done  = bus_ack | tmr_expire;
    assign rdata = bus_ack ? bus_rdata : ERR_RDATA;

    always_comb begin
        state_d     = state_q;
        ibuf_v_d    = ibuf_v_q;
        ibuf_tag_d  = ibuf_tag_q;
        inst_data_d = inst_data_q;
        mem_din_d   = mem_din_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_err_d   = bus_err_q;
        // Pipeline advanced: the MEM slot that owned the data buffer is gone.
        dbuf_v_d    = mem_stall ? dbuf_v_q : 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                // Data first: the MEM-stage instruction is the older one.
                if (d_pend) begin
                    state_d     = ARB_DATA;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_wen;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_dout;
                end else if (i_pend) begin
                    state_d    = ARB_INST;
                    bus_req_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_addr_d = inst_addr;  // doubles as the pending fetch tag
                end
            end
            ARB_DATA, ARB_INST: begin
                if (done) begin
                    state_d   = ARB_IDLE;
                    bus_req_d = 1'b0;
                    if (!bus_ack) bus_err_d = 1'b1;
                    if (state_q == ARB_DATA) begin
                        mem_din_d = rdata;
                        dbuf_v_d  = 1'b1;
                    end else begin
                        inst_data_d = rdata;
                        ibuf_tag_d  = bus_addr_q;
                        ibuf_v_d    = 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            ibuf_v_q    <= 1'b0;
            dbuf_v_q    <= 1'b0;
            ibuf_tag_q  <= '0;
            inst_data_q <= '0;
            mem_din_q   <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ibuf_v_q    <= ibuf_v_d;
            dbuf_v_q    <= dbuf_v_d;
            ibuf_tag_q  <= ibuf_tag_d;
            inst_data_q <= inst_data_d;
            mem_din_q   <= mem_din_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign inst_data = inst_data_q;
    assign mem_din   = mem_din_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_err   = bus_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a memory responder pops the expected bus
// transaction queue whenever a request starts; the main flow checks stall
// lengths and buffered results.
module tb_mem_port_arbiter;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_ren = 1'b0, mem_ren = 1'b0, mem_wen = 1'b0;
    logic [31:0] inst_addr = '0, mem_addr = '0, mem_dout = '0;
    logic [31:0] inst_data, mem_din, bus_addr, bus_wdata;
    logic        mem_stall, bus_req, bus_we, bus_err;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '1;

    bus_txn_t exp_bus[$];
    bus_txn_t cur;
    int chk_cnt = 0, pass_cnt = 0;
    int lat = 1, age = 0, stray = 0, bus_cnt = 0;
    int n, n0;

    mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .mem_din(mem_din), .mem_stall(mem_stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] rdata_for(input logic [31:0] a);
        case (a)
            32'h4:   return 32'h2008_0005;
            32'h40:  return 32'h1234_5678;
            32'h10:  return 32'hAAAA_0010;
            32'h100: return 32'hBBBB_0100;
            default: return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    function automatic bus_txn_t txn(input logic we, input logic [31:0] a, input logic [31:0] d);
        bus_txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        return t;
    endfunction

    // Memory model: ack in the lat-th cycle of a request (lat=0: never).
    always @(negedge clk) begin
        if (bus_req) begin
            age++;
            if (age == 1) begin
                if (exp_bus.size() == 0) chk("bus_unexpected", bus_addr, 32'hFFFF_FFFF);
                else begin
                    cur = exp_bus.pop_front();
                    bus_cnt++;
                    chk("bus_we", {31'b0, bus_we}, {31'b0, cur.we});
                    chk("bus_addr", bus_addr, cur.addr);
                    if (cur.we) chk("bus_wdata", bus_wdata, cur.wdata);
                end
            end else begin
                chk("bus_addr_stable", bus_addr, cur.addr);
            end
            if (lat != 0 && age == lat) begin
                bus_ack = 1'b1; bus_rdata = rdata_for(bus_addr);
            end else begin
                bus_ack = 1'b0; bus_rdata = '1;
            end
        end else begin
            age = 0;
            bus_ack = (stray != 0);
            bus_rdata = (stray != 0) ? 32'hDEAD_BEEF : '1;
        end
    end

    task automatic adv();
        @(posedge clk); #1;
    endtask

    task automatic count_stall(output int cnt);
        cnt = 0;
        @(negedge clk);
        while (mem_stall && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_stall", {31'b0, mem_stall}, 32'd1);
        adv(); @(negedge clk);
        chk("rst_req", {31'b0, bus_req}, 32'd0);
        chk("rst_err", {31'b0, bus_err}, 32'd0);
        chk("rst_inst_data", inst_data, 32'd0);
        chk("rst_mem_din", mem_din, 32'd0);
        adv(); rst_n = 1'b1;
        @(negedge clk);
        chk("idle_stall", {31'b0, mem_stall}, 32'd0);

        // Fetch miss then hit
        adv(); inst_ren = 1'b1; inst_addr = 32'h4; lat = 1;
        exp_bus.push_back(txn(1'b0, 32'h4, 32'h0));
        count_stall(n);
        chk("fetch_miss_stall", n, 32'd2);
        chk("fetch_data", inst_data, 32'h2008_0005);
        adv(); count_stall(n);
        chk("fetch_hit_stall", n, 32'd0);

        // Simultaneous load and fetch miss: data first, idle gap, then fetch
        adv(); mem_ren = 1'b1; mem_addr = 32'h40; inst_addr = 32'h8; lat = 2;
        exp_bus.push_back(txn(1'b0, 32'h40, 32'h0));
        exp_bus.push_back(txn(1'b0, 32'h8, 32'h0));
        count_stall(n);
        chk("ld_fetch_stall", n, 32'd6);
        chk("ld_data", mem_din, 32'h1234_5678);
        chk("ld_fetch_data", inst_data, 32'h5A5A_0008);

        // Two back-to-back stores
        adv(); mem_ren = 1'b0; mem_wen = 1'b1; mem_addr = 32'h80;
        mem_dout = 32'hCAFE_F00D; lat = 1; n0 = bus_cnt;
        exp_bus.push_back(txn(1'b1, 32'h80, 32'hCAFE_F00D));
        count_stall(n);
        chk("st_stall", n, 32'd2);
        chk("st_one_write", bus_cnt - n0, 32'd1);
        adv(); mem_addr = 32'h84; mem_dout = 32'h0BAD_BEEF;
        exp_bus.push_back(txn(1'b1, 32'h84, 32'h0BAD_BEEF));
        count_stall(n);
        chk("st2_stall", n, 32'd2);

        // Redirect during a fetch: old fetch completes, then refetch
        adv(); mem_wen = 1'b0; inst_addr = 32'h10; lat = 3;
        exp_bus.push_back(txn(1'b0, 32'h10, 32'h0));
        exp_bus.push_back(txn(1'b0, 32'h100, 32'h0));
        adv(); inst_addr = 32'h100;
        count_stall(n);
        chk("redirect_stall", n, 32'd7);
        chk("redirect_data", inst_data, 32'hBBBB_0100);

        // Timeout on a load, then a stray ack
        adv(); mem_ren = 1'b1; mem_addr = 32'h200; lat = 0;
        exp_bus.push_back(txn(1'b0, 32'h200, 32'h0));
        count_stall(n);
        chk("tmo_stall", n, 32'd65);
        chk("tmo_err", {31'b0, bus_err}, 32'd1);
        chk("tmo_din", mem_din, 32'h0);
        chk("tmo_req", {31'b0, bus_req}, 32'd0);
        adv(); mem_ren = 1'b0; stray = 1;
        adv(); stray = 0;
        @(negedge clk);
        chk("stray_din", mem_din, 32'h0);
        chk("stray_req", {31'b0, bus_req}, 32'd0);
        chk("stray_stall", {31'b0, mem_stall}, 32'd0);
        chk("stray_err_sticky", {31'b0, bus_err}, 32'd1);

        // Reset in the middle of a transaction
        adv(); mem_ren = 1'b1; mem_addr = 32'h300; lat = 0;
        exp_bus.push_back(txn(1'b0, 32'h300, 32'h0));
        adv(); adv(); @(negedge clk);
        chk("mid_req", {31'b0, bus_req}, 32'd1);
        adv(); rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_stall", {31'b0, mem_stall}, 32'd1);
        adv(); @(negedge clk);
        chk("mid_rst_req", {31'b0, bus_req}, 32'd0);
        chk("mid_rst_we", {31'b0, bus_we}, 32'd0);
        chk("mid_rst_addr", bus_addr, 32'd0);
        chk("mid_rst_wdata", bus_wdata, 32'd0);
        chk("mid_rst_err", {31'b0, bus_err}, 32'd0);
        chk("mid_rst_inst", inst_data, 32'd0);
        chk("mid_rst_din", mem_din, 32'd0);
        adv(); rst_n = 1'b1; mem_ren = 1'b0; inst_ren = 1'b0; stray = 1;
        @(negedge clk);
        chk("post_rst_stall", {31'b0, mem_stall}, 32'd0);
        adv(); stray = 0;
        @(negedge clk);
        chk("post_rst_req", {31'b0, bus_req}, 32'd0);
        chk("post_rst_din", mem_din, 32'd0);
        // Fetch buffer was cleared by reset, so this address misses again
        adv(); inst_ren = 1'b1; inst_addr = 32'h100; lat = 1;
        exp_bus.push_back(txn(1'b0, 32'h100, 32'h0));
        count_stall(n);
        chk("post_rst_miss_stall", n, 32'd2);
        chk("post_rst_fetch", inst_data, 32'hBBBB_0100);

        adv(); inst_ren = 1'b0;
        @(negedge clk);
        chk("bus_queue_empty", exp_bus.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
